led_matrix_scan: RTL and testbench

Row-scanning display driver for the 8x8 Life board. It sits directly downstream of the generation engine and consumes the engine's 64-bit `grid` output. It double-buffers frames so that a new generation is only shown at a frame boundary, which prevents tearing. It drives one row at a time onto an 8x8 LED matrix and reports the live-cell count of the frame currently on display.

---
 rtl/led_matrix_scan.sv | 151 +++++++++++++++
 tb/tb_led_matrix_scan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// Row-scanning 8x8 LED driver with double-buffered frames and live-cell count.
// Latency: outputs registered, reflecting the state entered on the same edge; loads show at next frame boundary (immediately when idle).
// Backpressure: none; load is a strobe, latest pending frame wins, en low blanks the display.
module led_matrix_scan #(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [63:0] grid,
    output logic [7:0]  row_sel,
    output logic [7:0]  col,
    output logic        frame_done,
    output logic [6:0]  pop_count
);

    typedef enum logic [1:0] {IDLE, BLNK, DRV} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);

    state_t      st, st_nxt;
    logic [2:0]  r, r_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        boundary;

    logic [63:0] disp, pend;
    logic        pend_v;
    logic        swap_ok;
    logic        disp_wr;
    logic [63:0] disp_src;

    function automatic logic [6:0] ones64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    // Scan state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= IDLE;
            r   <= 3'd0;
            cnt <= 8'd0;
        end else begin
            st  <= st_nxt;
            r   <= r_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Next-state: blank then drive each row; wrapping out of row 7 is the frame boundary
    always_comb begin
        st_nxt   = st;
        r_nxt    = r;
        cnt_nxt  = cnt;
        boundary = 1'b0;
        if (!en) begin
            st_nxt  = IDLE;
            r_nxt   = 3'd0;
            cnt_nxt = 8'd0;
        end else begin
            case (st)
                IDLE: begin
                    st_nxt  = BLNK;
                    r_nxt   = 3'd0;
                    cnt_nxt = 8'd0;
                end
                BLNK: begin
                    if (cnt == BLANK_LAST) begin
                        st_nxt  = DRV;
                        cnt_nxt = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                DRV: begin
                    if (cnt == DWELL_LAST) begin
                        st_nxt   = BLNK;
                        r_nxt    = r + 3'd1;
                        cnt_nxt  = 8'd0;
                        boundary = (r == 3'd7);
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                default: begin
                    st_nxt  = IDLE;
                    r_nxt   = 3'd0;
                    cnt_nxt = 8'd0;
                end
            endcase
        end
    end

    // Swap source: a coincident load beats a waiting frame
    always_comb begin
        swap_ok  = boundary || (st == IDLE);
        disp_wr  = 1'b0;
        disp_src = grid;
        if (swap_ok) begin
            if (load) begin
                disp_wr  = 1'b1;
                disp_src = grid;
            end else if (pend_v) begin
                disp_wr  = 1'b1;
                disp_src = pend;
            end
        end
    end

    // Frame buffers; pop_count tracks whatever is written into disp
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp      <= 64'd0;
            pend      <= 64'd0;
            pend_v    <= 1'b0;
            pop_count <= 7'd0;
        end else begin
            if (disp_wr) begin
                disp      <= disp_src;
                pop_count <= ones64(disp_src);
            end
            if (swap_ok) begin
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= grid;
                pend_v <= 1'b1;
            end
        end
    end

    // Registered drive outputs follow the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_sel    <= 8'd0;
            col        <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            row_sel    <= (st_nxt == DRV) ? (8'b1 << r_nxt) : 8'd0;
            col        <= (st_nxt == DRV) ? disp[{r_nxt, 3'b000} +: 8] : 8'd0;
            frame_done <= (st_nxt == BLNK) && (r_nxt == 3'd0) && (st != BLNK);
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
module tb_led_matrix_scan;

    logic        clk = 1'b0;
    logic        reset, en, load;
    logic [63:0] grid;
    logic [7:0]  row_sel, col;
    logic        frame_done;
    logic [6:0]  pop_count;
    logic [23:0] obs;
    logic [23:0] expv;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] G1 = 64'h303A102C80E83818;

    led_matrix_scan dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .grid       (grid),
        .row_sel    (row_sel),
        .col        (col),
        .frame_done (frame_done),
        .pop_count  (pop_count)
    );

    always #5 clk = ~clk;

    assign obs = {row_sel, col, frame_done, pop_count};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_v);
        reset = 1'b1;
        en    = en_v;
        load  = 1'b0;
        grid  = 64'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Expected {row_sel, col, frame_done, pop_count} at cycle k of a scan started at k=0
    // with defaults (1 blank + 4 drive cycles per row, 40-cycle frame).
    function automatic logic [23:0] exp_obs(input int k, input logic [63:0] d, input logic [6:0] p);
        int         ph;
        int         row;
        logic [7:0] rs;
        logic [7:0] c;
        ph  = k % 5;
        row = (k / 5) % 8;
        rs  = (ph == 0) ? 8'h00 : (8'h01 << row);
        c   = (ph == 0) ? 8'h00 : d[8*row +: 8];
        return {rs, c, 1'((k % 40) == 0), p};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        grid  = 64'd0;
        #1;
        checks++;
        if (obs !== 24'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required %h", obs, 24'd0);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (obs !== 24'd0) begin
            failures++;
            $display("FAIL idle_dark: got %h required %h", obs, 24'd0);
        end
    endtask

    task automatic test_idle_load();
        do_reset(1'b0);
        grid = G1;
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (obs !== {8'h00, 8'h00, 1'b0, 7'd20}) begin
            failures++;
            $display("FAIL idle_load_pop: got %h required %h", obs, {8'h00, 8'h00, 1'b0, 7'd20});
        end
        en = 1'b1;
        step();
        for (int k = 0; k < 85; k++) begin
            expv = exp_obs(k, G1, 7'd20);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL scan_timing k=%0d: got %h required %h", k, obs, expv);
            end
            step();
        end
    endtask

    task automatic test_midframe();
        do_reset(1'b0);
        grid = G1;
        load = 1'b1;
        step();
        load = 1'b0;
        en   = 1'b1;
        step();
        for (int k = 0; k < 46; k++) begin
            expv = (k < 40) ? exp_obs(k, G1, 7'd20) : exp_obs(k, {64{1'b1}}, 7'd64);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL midframe_load k=%0d: got %h required %h", k, obs, expv);
            end
            if (k == 16) begin
                grid = {64{1'b1}};
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end
    endtask

    task automatic test_two_loads();
        do_reset(1'b1);
        step();
        for (int k = 0; k < 126; k++) begin
            if (k < 40)      expv = exp_obs(k, 64'd0, 7'd0);
            else if (k < 80) expv = exp_obs(k, 64'h3, 7'd2);
            else             expv = exp_obs(k, 64'hFF00, 7'd8);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL two_loads k=%0d: got %h required %h", k, obs, expv);
            end
            load = 1'b1;
            case (k)
                5:       grid = 64'h1;
                10:      grid = 64'h3;
                50:      grid = 64'h1;
                79:      grid = 64'hFF00;
                default: load = 1'b0;
            endcase
            step();
            load = 1'b0;
        end
    endtask

    task automatic test_en_drop();
        do_reset(1'b0);
        grid = G1;
        load = 1'b1;
        step();
        load = 1'b0;
        en   = 1'b1;
        step();
        for (int k = 0; k <= 26; k++) begin
            expv = exp_obs(k, G1, 7'd20);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL en_drop_pre k=%0d: got %h required %h", k, obs, expv);
            end
            if (k < 26) step();
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {8'h00, 8'h00, 1'b0, 7'd20}) begin
                failures++;
                $display("FAIL en_drop_dark i=%0d: got %h required %h", i, obs, {8'h00, 8'h00, 1'b0, 7'd20});
            end
        end
        en = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            expv = exp_obs(k, G1, 7'd20);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL en_restart k=%0d: got %h required %h", k, obs, expv);
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        grid = G1;
        load = 1'b1;
        step();
        load = 1'b0;
        en   = 1'b1;
        step();
        for (int k = 0; k < 22; k++) begin
            if (k == 10) begin
                grid = 64'hFFFF;
                load = 1'b1;
            end
            step();
            load = 1'b0;
        end
        checks++;
        if (obs !== exp_obs(22, G1, 7'd20)) begin
            failures++;
            $display("FAIL reset_mid_pre: got %h required %h", obs, exp_obs(22, G1, 7'd20));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 24'd0) begin
            failures++;
            $display("FAIL reset_mid_async: got %h required %h", obs, 24'd0);
        end
        step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 51; k++) begin
            expv = exp_obs(k, 64'd0, 7'd0);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reset_mid_post k=%0d: got %h required %h", k, obs, expv);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_idle_load();
        test_midframe();
        test_two_loads();
        test_en_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
